arm_multicycle: RTL and testbench
=================================

ARM_MULTICYCLE -- requirements
Module: arm_multicycle

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter LINK_REG, default 14, register index written by BL.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port MemAdr  output  32  unified instruction/data memory address.
REQ-006 Port MemRead  output  1  read request; held high until MemReady.
REQ-007 Port MemWrite  output  1  write request; held high until MemReady.
REQ-008 Port WriteData  output  32  store data; valid whenever MemWrite=1.
REQ-009 Port ReadData  input  32  read data; sampled on the edge where MemReady=1.
REQ-010 Port MemReady  input  1  memory completes the current request this cycle; zero or more wait cycles allowed.
REQ-011 Port State  output  4  current FSM state encoding, for debug.

Function
REQ-012 The block SHALL be a multicycle ARM core with one memory port, 16x32 register file, NZCV flags, and FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
REQ-013 Supported instructions SHALL be: AND/SUB/ADD/ORR (cmd 0000/0010/0100/1100) with register (unshifted) or rotated 8-bit immediate operand, S bit; LDR/STR with 12-bit immediate offset, U bit add/subtract, P=1 W=0 only; B and BL.
REQ-014 FETCH: MemAdr=PC, MemRead=1; stay while MemReady=0; on MemReady=1 latch ReadData into instruction register, PC<=PC+4, go DECODE.
REQ-015 DECODE: read Rn/Rm/Rd; R15 SHALL read as fetch address+8; next state by op: memory->MEMADR, data-processing reg->EXECR, imm->EXECI, branch->BRANCH.
REQ-016 Condition field SHALL be evaluated in DECODE against current flags (all 15 ARM codes, 1111 treated as never); failed condition SHALL return to FETCH with no register, flag, or memory side effect.
REQ-017 EXECR/EXECI: compute ALU result; go ALUWB; ALUWB writes Rd, updates flags if S=1, then FETCH.
REQ-018 Flags: N=result[31], Z=(result==0), C=carry-out for ADD, not-borrow for SUB, unchanged for AND/ORR; V=signed overflow for ADD/SUB, unchanged for AND/ORR.
REQ-019 Writing Rd=15 from ALUWB or MEMWB SHALL load PC with that value (no +4).
REQ-020 MEMADR: address=Rn±imm12 by U; LDR->MEMREAD, STR->MEMWRITE.
REQ-021 MEMREAD: MemAdr=address, MemRead=1, wait for MemReady; capture ReadData; go MEMWB; MEMWB writes Rd, then FETCH.
REQ-022 MEMWRITE: MemAdr=address, MemWrite=1, WriteData=Rd, held stable until MemReady=1, then FETCH.
REQ-023 BRANCH: PC<=(fetch address+8)+(sign-extended imm24<<2); BL additionally writes fetch address+4 into R[LINK_REG]; then FETCH.
REQ-024 MemRead and MemWrite SHALL never be high together; both SHALL be 0 in all states other than FETCH, MEMREAD, MEMWRITE.
REQ-025 Unsupported encodings SHALL execute as no-op (return to FETCH from DECODE).
REQ-026 Arithmetic SHALL be 32-bit modulo; PC+4 wraps 32'hFFFF_FFFC -> 0.
REQ-027 Minimum cycle counts with MemReady always 1: data-processing 4, LDR 5, STR 4, B/BL 3, failed condition 2.

Reset
REQ-028 On reset=1 at a clock edge: state<=FETCH, PC<=RESET_PC, flags<=0000, MemRead and MemWrite low in that cycle; register file R0-R14 not reset.
REQ-029 Reset asserted mid-request (e.g. MEMWRITE waiting on MemReady) SHALL abandon the request with no register or flag update; MemWrite SHALL be 0 the cycle reset is applied.

Verification
REQ-030 Reset then MemReady=1, program MOV-equivalent ADD R0,R15,#0 at 0 -> R0=8 after 4 cycles, PC=4.
REQ-031 SUBS R1,R1,R1 with R1=5 -> R1=0, flags NZCV=0110; next BEQ taken to target, BNE at same point skipped in 2 cycles.
REQ-032 STR R2,[R3,#4] with R3=0x100, R2=0xDEADBEEF, MemReady low 3 cycles -> MemAdr=0x104, WriteData=0xDEADBEEF, MemWrite high exactly 4 cycles, then FETCH.
REQ-033 LDR R4,[R3,#-4] with R3=0x100, memory 0xFC=0x12345678 -> R4=0x12345678 after 5 cycles.
REQ-034 BL at 0x20 with imm24=2 -> PC=0x30, R14=0x24.
REQ-035 Reset asserted during MEMREAD wait -> next cycle State=FETCH, MemAdr=RESET_PC, target Rd unchanged.

Source files
------------

// File: rtl/arm_multicycle.sv
// Multicycle ARM subset core with a single unified memory port.
// Ten-state FSM: fetch, decode, then memory, ALU or branch sequences.
module arm_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          LINK_REG = 14
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] MemAdr,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  input  logic        MemReady,
  output logic [3:0]  State
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_SUB = 4'b0010;
  localparam logic [3:0] C_ADD = 4'b0100;
  localparam logic [3:0] C_ORR = 4'b1100;

  logic [3:0]  state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] a_q, b_q, d_q;
  logic [31:0] alu_q;
  logic [3:0]  fl_q;
  logic [3:0]  nzcv_q;
  logic [31:0] adr_q;
  logic [31:0] data_q;
  logic [31:0] rf_q [16];

  logic [3:0] cond, cmd, rn, rd, rm;
  logic [1:0] op;
  logic       s_bit;
  assign cond  = ir_q[31:28];
  assign op    = ir_q[27:26];
  assign cmd   = ir_q[24:21];
  assign s_bit = ir_q[20];
  assign rn    = ir_q[19:16];
  assign rd    = ir_q[15:12];
  assign rm    = ir_q[3:0];

  // R15 reads as fetch address + 8; pc_q already holds fetch + 4
  logic [31:0] pc8, rn_v, rm_v, rd_v;
  assign pc8  = pc_q + 32'd4;
  assign rn_v = (rn == 4'hF) ? pc8 : rf_q[rn];
  assign rm_v = (rm == 4'hF) ? pc8 : rf_q[rm];
  assign rd_v = (rd == 4'hF) ? pc8 : rf_q[rd];

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = nzcv_q;

  logic base_ok, cond_ok;
  always_comb begin
    base_ok = 1'b1;
    unique case (cond[3:1])
      3'b000:  base_ok = z_f;
      3'b001:  base_ok = c_f;
      3'b010:  base_ok = n_f;
      3'b011:  base_ok = v_f;
      3'b100:  base_ok = c_f & ~z_f;
      3'b101:  base_ok = (n_f == v_f);
      3'b110:  base_ok = ~z_f & (n_f == v_f);
      default: base_ok = 1'b1;
    endcase
  end
  // low bit inverts; 1111 therefore evaluates as never
  assign cond_ok = base_ok ^ cond[0];

  logic cmd_ok, is_dp, is_mem, is_br;
  assign cmd_ok = (cmd == C_AND) || (cmd == C_SUB) ||
                  (cmd == C_ADD) || (cmd == C_ORR);
  assign is_dp  = (op == 2'b00) && cmd_ok &&
                  (ir_q[25] || (ir_q[11:4] == 8'h00));
  assign is_mem = (op == 2'b01) && !ir_q[25] && ir_q[24] &&
                  !ir_q[22] && !ir_q[21];
  assign is_br  = (op == 2'b10) && ir_q[25];

  logic [63:0] imm_dbl;
  logic [31:0] rot_imm, srcb, bb, res;
  logic [32:0] sum;
  logic        sub, arith;
  assign imm_dbl = {24'h0, ir_q[7:0], 24'h0, ir_q[7:0]}
                   >> {ir_q[11:8], 1'b0};
  assign rot_imm = imm_dbl[31:0];
  assign srcb    = ir_q[25] ? rot_imm : b_q;
  assign sub     = (cmd == C_SUB);
  assign arith   = (cmd == C_SUB) || (cmd == C_ADD);
  assign bb      = sub ? ~srcb : srcb;
  assign sum     = {1'b0, a_q} + {1'b0, bb} + {32'h0, sub};

  always_comb begin
    res = sum[31:0];
    unique case (cmd)
      C_AND:   res = a_q & srcb;
      C_ORR:   res = a_q | srcb;
      default: res = sum[31:0];
    endcase
  end

  logic [3:0] fl_d;
  assign fl_d[3] = res[31];
  assign fl_d[2] = (res == 32'h0);
  assign fl_d[1] = arith ? sum[32] : c_f;
  assign fl_d[0] = arith ? ((a_q[31] == bb[31]) &&
                            (res[31] != a_q[31])) : v_f;

  logic [31:0] br_off;
  assign br_off = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_ok)    state_d = S_FETCH;
        else if (is_mem) state_d = S_MEMADR;
        else if (is_dp)  state_d = ir_q[25] ? S_EXECI : S_EXECR;
        else if (is_br)  state_d = S_BRANCH;
        else             state_d = S_FETCH;
      end
      S_MEMADR: state_d = ir_q[20] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      nzcv_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_FETCH: if (MemReady) begin
          ir_q <= ReadData;
          pc_q <= pc_q + 32'd4;
        end
        S_DECODE: begin
          a_q <= rn_v;
          b_q <= rm_v;
          d_q <= rd_v;
        end
        S_EXECR, S_EXECI: begin
          alu_q <= res;
          fl_q  <= fl_d;
        end
        S_ALUWB: begin
          if (s_bit)        nzcv_q <= fl_q;
          if (rd == 4'hF)   pc_q   <= alu_q;
        end
        S_MEMADR: adr_q <= ir_q[23] ? a_q + {20'h0, ir_q[11:0]}
                                    : a_q - {20'h0, ir_q[11:0]};
        S_MEMRD:  if (MemReady) data_q <= ReadData;
        S_MEMWB:  if (rd == 4'hF) pc_q <= data_q;
        S_BRANCH: pc_q <= pc8 + br_off;
        default:  ;
      endcase
    end
  end

  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  always_comb begin
    rf_we = 1'b0;
    rf_wa = rd;
    rf_wd = alu_q;
    unique case (state_q)
      S_ALUWB:  rf_we = 1'b1;
      S_MEMWB:  begin rf_we = 1'b1; rf_wd = data_q; end
      S_BRANCH: begin
        rf_we = ir_q[24];
        rf_wa = 4'(LINK_REG);
        rf_wd = pc_q;
      end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && rf_we && rf_wa != 4'hF)
      rf_q[rf_wa] <= rf_wd;
  end

  assign MemAdr    = (state_q == S_MEMRD || state_q == S_MEMWR)
                     ? adr_q : pc_q;
  assign MemRead   = !reset &&
                     (state_q == S_FETCH || state_q == S_MEMRD);
  assign MemWrite  = !reset && (state_q == S_MEMWR);
  assign WriteData = d_q;
  assign State     = state_q;

endmodule

// File: tb/tb_arm_multicycle.sv
// Directed program bench for arm_multicycle with a wait-state memory.
module tb_arm_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] MemAdr, WriteData, ReadData;
  logic        MemRead, MemWrite, MemReady;
  logic [3:0]  State;
  logic [31:0] mem [256];
  logic        rdy = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;
  int          mw;

  always #5 clk = ~clk;

  assign ReadData = mem[MemAdr[9:2]];
  assign MemReady = rdy;

  arm_multicycle dut (
    .clk       (clk),
    .reset     (reset),
    .MemAdr    (MemAdr),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .MemReady  (MemReady),
    .State     (State)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input int exp);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (State !== 4'd0 && c < 40);
    chk(tag, 32'(c), 32'(exp));
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    mem[0]  = 32'hE28F0000;
    mem[1]  = 32'hE2401003;
    mem[2]  = 32'hE0511001;
    mem[3]  = 32'h1A000005;
    mem[4]  = 32'h0A000002;
    mem[5]  = 32'hE2800001;
    mem[6]  = 32'hE2800001;
    mem[7]  = 32'hE2800001;
    mem[8]  = 32'hEB000002;
    mem[9]  = 32'hE2800001;
    mem[10] = 32'hE2800001;
    mem[11] = 32'hE2800001;
    mem[12] = 32'hE28030F8;
    mem[13] = 32'hE5932100;
    mem[14] = 32'hE5832004;
    mem[15] = 32'hE5134004;
    mem[16] = 32'hE280F048;
    mem[17] = 32'hE2800001;
    mem[18] = 32'hE2800001;
    mem[19] = 32'hE2800001;
    mem[20] = 32'hE38360FF;
    mem[21] = 32'hE0067002;
    mem[22] = 32'hE0928002;
    mem[23] = 32'hE7000000;
    mem[24] = 32'hF0000000;
    mem[25] = 32'hE28054FF;
    mem[26] = 32'hE5935000;
    mem[63]  = 32'h12345678;
    mem[128] = 32'hDEADBEEF;

    reset = 1'b1;
    step();
    step();
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_pc", dut.pc_q, 32'h0);
    chk("rst_nzcv", 32'(dut.nzcv_q), 32'h0);
    reset = 1'b0;
    #1;
    chk("fetch_memread", 32'(MemRead), 32'd1);
    chk("fetch_adr", MemAdr, 32'h0);

    run("add_r15_cyc", 4);
    chk("r0", dut.rf_q[0], 32'h8);
    chk("pc_after_add", dut.pc_q, 32'h4);

    run("sub_imm_cyc", 4);
    chk("r1_5", dut.rf_q[1], 32'h5);

    run("subs_cyc", 4);
    chk("r1_0", dut.rf_q[1], 32'h0);
    chk("subs_nzcv", 32'(dut.nzcv_q), 32'h6);

    run("bne_cyc", 2);
    chk("bne_pc", dut.pc_q, 32'h10);

    run("beq_cyc", 3);
    chk("beq_pc", dut.pc_q, 32'h20);
    chk("beq_r0", dut.rf_q[0], 32'h8);

    run("bl_cyc", 3);
    chk("bl_pc", dut.pc_q, 32'h30);
    chk("bl_r14", dut.rf_q[14], 32'h24);

    run("add_r3_cyc", 4);
    chk("r3", dut.rf_q[3], 32'h100);

    run("ldr_r2_cyc", 5);
    chk("r2", dut.rf_q[2], 32'hDEADBEEF);

    step();
    step();
    step();
    chk("str_state", 32'(State), 32'd5);
    mw = 0;
    for (int i = 0; i < 4; i++) begin
      rdy = (i == 3);
      if (MemWrite) mw++;
      chk("str_adr", MemAdr, 32'h104);
      chk("str_wdata", WriteData, 32'hDEADBEEF);
      chk("str_noread", 32'(MemRead), 32'd0);
      step();
    end
    chk("str_mw_cycles", 32'(mw), 32'd4);
    chk("str_done_state", 32'(State), 32'd0);
    chk("str_mw_low", 32'(MemWrite), 32'd0);

    run("ldr_r4_cyc", 5);
    chk("r4", dut.rf_q[4], 32'h12345678);

    run("add_pc_cyc", 4);
    chk("add_pc", dut.pc_q, 32'h50);
    chk("add_pc_r0", dut.rf_q[0], 32'h8);

    run("orr_cyc", 4);
    chk("r6_orr", dut.rf_q[6], 32'h1FF);
    run("and_cyc", 4);
    chk("r7_and", dut.rf_q[7], 32'hEF);
    run("adds_cyc", 4);
    chk("r8_adds", dut.rf_q[8], 32'hBD5B7DDE);
    chk("adds_nzcv", 32'(dut.nzcv_q), 32'hA);

    run("undef_cyc", 2);
    chk("undef_pc", dut.pc_q, 32'h60);
    run("never_cyc", 2);
    chk("never_pc", dut.pc_q, 32'h64);
    chk("never_nzcv", 32'(dut.nzcv_q), 32'hA);

    run("rot_imm_cyc", 4);
    chk("r5_rot", dut.rf_q[5], 32'hFF000008);

    step();
    step();
    step();
    chk("ldr_wait_state", 32'(State), 32'd3);
    rdy = 1'b0;
    step();
    step();
    chk("ldr_wait_hold", 32'(State), 32'd3);
    chk("ldr_wait_adr", MemAdr, 32'h100);
    chk("ldr_wait_rd", 32'(MemRead), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_memread", 32'(MemRead), 32'd0);
    step();
    reset = 1'b0;
    rdy = 1'b1;
    chk("rst_mid_state", 32'(State), 32'd0);
    chk("rst_mid_adr", MemAdr, 32'h0);
    chk("rst_mid_r5", dut.rf_q[5], 32'hFF000008);
    chk("rst_mid_nzcv", 32'(dut.nzcv_q), 32'h0);

    run("restart_cyc", 4);
    chk("restart_pc", dut.pc_q, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
